// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding, command codes, BCD limit.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRunning = 3'd1,
        StLap     = 3'd2,
        StPaused  = 3'd3,
        StDone    = 3'd4
    } state_e;

    localparam logic [1:0] CmdStart = 2'b00;
    localparam logic [1:0] CmdStop  = 2'b01;
    localparam logic [1:0] CmdClear = 2'b10;
    localparam logic [1:0] CmdLap   = 2'b11;

    localparam logic [3:0] BcdMax = 4'd9;

    // True when the three-digit counter reads 999.
    function automatic logic bcd_all_max(input logic [3:0] h, input logic [3:0] t,
                                         input logic [3:0] o);
        return (h == BcdMax) && (t == BcdMax) && (o == BcdMax);
    endfunction

endpackage

// File: rtl/stopwatch_tick.sv
// Prescaler: counts 0..TICK_DIV-1 while run is high; tick flags the wrapping edge.
module stopwatch_tick #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] Last = CW'(TICK_DIV - 1);

    logic [CW-1:0] pre_q;
    logic [CW-1:0] pre_d;

    // Next prescaler value: clear wins, otherwise advance only while running.
    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (run) begin
            pre_d = (pre_q == Last) ? '0 : pre_q + CW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // High during the cycle whose closing edge performs the wrap.
    assign tick = run && (pre_q == Last);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: command FSM, step gating toward the external BCD chain, lap latch.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter bit          WRAP     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [3:0] cnt_h,
    input  logic [3:0] cnt_t,
    input  logic [3:0] cnt_o,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [3:0] disp_h,
    output logic [3:0] disp_t,
    output logic [3:0] disp_o,
    output logic       running,
    output logic       lap_active,
    output logic       done,
    output logic [2:0] state
);

    state_e      state_q, state_d;
    logic        cnt_en_q, cnt_clr_q;
    logic        running_q, lap_q, done_q;
    logic [11:0] disp_q, disp_d;

    logic tick;
    logic step;
    logic clr_acc;
    logic c_start, c_stop, c_clear, c_lap;
    logic halt;

    assign c_start = cmd_valid && (cmd == CmdStart);
    assign c_stop  = cmd_valid && (cmd == CmdStop);
    assign c_clear = cmd_valid && (cmd == CmdClear);
    assign c_lap   = cmd_valid && (cmd == CmdLap);

    // running_q mirrors "state_q is RUNNING or LAP", so it doubles as the prescaler enable.
    stopwatch_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .run   (running_q),
        .clear (clr_acc),
        .tick  (tick)
    );

    // Counter at 999 on a wrap: stop there unless rolling over is allowed.
    assign halt = tick && !WRAP && bcd_all_max(cnt_h, cnt_t, cnt_o);

    // Next state, step gating and display source.
    always_comb begin
        state_d = state_q;
        clr_acc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (c_start) state_d = StRunning;
            end
            StRunning: begin
                if (c_stop) begin
                    state_d = StPaused;
                end else if (c_clear) begin
                    state_d = StIdle;
                    clr_acc = 1'b1;
                end else if (c_lap) begin
                    state_d = StLap;
                end
            end
            StLap: begin
                if (c_lap) begin
                    state_d = StRunning;
                end else if (c_stop) begin
                    state_d = StPaused;
                end else if (c_clear) begin
                    state_d = StIdle;
                    clr_acc = 1'b1;
                end
            end
            StPaused: begin
                if (c_start) begin
                    state_d = StRunning;
                end else if (c_clear) begin
                    state_d = StIdle;
                    clr_acc = 1'b1;
                end
            end
            StDone: begin
                if (c_clear) begin
                    state_d = StIdle;
                    clr_acc = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // STOP/CLEAR drop a coincident step; LAP keeps it.
        step = tick && !c_stop && !c_clear && !halt;

        // A halting wrap only takes effect when no command moved the FSM this edge.
        if (halt && (state_d == state_q)) state_d = StDone;

        // Freeze only while staying in LAP; entering LAP latches the pre-step digits.
        disp_d = ((state_q == StLap) && (state_d == StLap)) ? disp_q : {cnt_h, cnt_t, cnt_o};
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            running_q <= 1'b0;
            lap_q     <= 1'b0;
            done_q    <= 1'b0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_en_q  <= step;
            cnt_clr_q <= clr_acc;
            running_q <= (state_d == StRunning) || (state_d == StLap);
            lap_q     <= (state_d == StLap);
            done_q    <= (state_d == StDone);
            disp_q    <= disp_d;
        end
    end

    assign cnt_en                   = cnt_en_q;
    assign cnt_clr                  = cnt_clr_q;
    assign running                  = running_q;
    assign lap_active               = lap_q;
    assign done                     = done_q;
    assign state                    = state_q;
    assign {disp_h, disp_t, disp_o} = disp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4, WRAP=0, including a model of the external counter.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [3:0] cnt_h, cnt_t, cnt_o;
    logic       cnt_en, cnt_clr;
    logic [3:0] disp_h, disp_t, disp_o;
    logic       running, lap_active, done;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int cnt_v;

    // Reference model: mode, phase within the tick period, expected registered outputs.
    state_e m_state;
    int     m_phase;
    bit     m_en, m_clr;
    int     m_disp;

    stopwatch_ctrl #(
        .TICK_DIV (TD),
        .WRAP     (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cnt_h      (cnt_h),
        .cnt_t      (cnt_t),
        .cnt_o      (cnt_o),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .disp_h     (disp_h),
        .disp_t     (disp_t),
        .disp_o     (disp_o),
        .running    (running),
        .lap_active (lap_active),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic set_cnt(input int v);
        cnt_v = v;
        cnt_h = 4'(v / 100);
        cnt_t = 4'((v / 10) % 10);
        cnt_o = 4'(v % 10);
    endtask

    // Advance the model by one clock edge using the inputs presented right now.
    task automatic model_edge();
        bit     was_run, wrap, halt, s, p, c, l;
        state_e nxt;
        if (rst) begin
            m_state = StIdle; m_phase = 0; m_en = 0; m_clr = 0; m_disp = 0;
            return;
        end
        s = cmd_valid && cmd == CmdStart;
        p = cmd_valid && cmd == CmdStop;
        c = cmd_valid && cmd == CmdClear;
        l = cmd_valid && cmd == CmdLap;
        was_run = (m_state == StRunning) || (m_state == StLap);
        wrap = was_run && (m_phase == TD - 1);
        if (was_run) m_phase = (m_phase + 1) % TD;
        nxt = m_state;
        case (m_state)
            StIdle:    if (s) nxt = StRunning;
            StRunning: if (p) nxt = StPaused; else if (c) nxt = StIdle; else if (l) nxt = StLap;
            StLap:     if (l) nxt = StRunning; else if (p) nxt = StPaused; else if (c) nxt = StIdle;
            StPaused:  if (s) nxt = StRunning; else if (c) nxt = StIdle;
            default:   if (c) nxt = StIdle;
        endcase
        m_clr = c && (m_state != StIdle);
        if (m_clr) m_phase = 0;
        halt = wrap && (cnt_v == 999);
        m_en = wrap && !halt && !p && !c;
        if (halt && nxt == m_state) nxt = StDone;
        if (!(m_state == StLap && nxt == StLap)) m_disp = cnt_v;
        m_state = nxt;
    endtask

    // One clock: update model, cross the edge, then let the external counter react.
    task automatic cycle();
        bit en_b, clr_b;
        en_b  = (cnt_en === 1'b1);
        clr_b = (cnt_clr === 1'b1);
        model_edge();
        @(posedge clk);
        #1;
        if (clr_b) set_cnt(0);
        else if (en_b) set_cnt((cnt_v + 1) % 1000);
        cmd_valid = 1'b0;
    endtask

    task automatic cmd_cycle(input logic [1:0] c);
        cmd = c;
        cmd_valid = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd = CmdStart; cmd_valid = 1'b1;
        cycle();
        cmd = CmdStart; cmd_valid = 1'b1;
        cycle();
        rst = 1'b0;
        total++;
        if (state !== StIdle) begin
            bad++; $display("FAIL reset_state: got %0d want %0d", state, StIdle);
        end
        total++;
        if ({cnt_en, cnt_clr, running, lap_active, done} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000",
                            {cnt_en, cnt_clr, running, lap_active, done});
        end
        total++;
        if ({disp_h, disp_t, disp_o} !== 12'h000) begin
            bad++; $display("FAIL reset_disp: got %h want 000", {disp_h, disp_t, disp_o});
        end
        cmd_cycle(CmdStop);
        total++;
        if (state !== StIdle) begin
            bad++; $display("FAIL idle_ignores_stop: got %0d want %0d", state, StIdle);
        end
    endtask

    task automatic test_basic_run();
        int first, pulses;
        first = -1; pulses = 0;
        cmd_cycle(CmdStart);
        total++;
        if (state !== StRunning || running !== 1'b1) begin
            bad++; $display("FAIL run_start: got state=%0d running=%b want %0d/1",
                            state, running, StRunning);
        end
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (cnt_en === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        total++;
        if (pulses != 10) begin
            bad++; $display("FAIL run_pulses: got %0d want 10", pulses);
        end
        total++;
        if (first != 4) begin
            bad++; $display("FAIL run_first_pulse: got %0d want 4", first);
        end
        cmd_cycle(CmdClear);
        total++;
        if (cnt_clr !== 1'b1 || state !== StIdle) begin
            bad++; $display("FAIL run_clear: got clr=%b state=%0d want 1/%0d",
                            cnt_clr, state, StIdle);
        end
        cycle();
        total++;
        if (cnt_clr !== 1'b0) begin
            bad++; $display("FAIL run_clear_width: got %b want 0", cnt_clr);
        end
    endtask

    task automatic test_pause_phase();
        bit saw_en;
        int gap;
        saw_en = 0; gap = -1;
        cmd_cycle(CmdStart);
        repeat (5) cycle();
        cmd_cycle(CmdStop);
        total++;
        if (state !== StPaused || running !== 1'b0) begin
            bad++; $display("FAIL pause_state: got %0d running=%b want %0d/0",
                            state, running, StPaused);
        end
        repeat (20) begin
            cycle();
            if (cnt_en !== 1'b0) saw_en = 1;
        end
        total++;
        if (saw_en) begin
            bad++; $display("FAIL pause_no_step: got step while paused want none");
        end
        cmd_cycle(CmdStart);
        total++;
        if (state !== StRunning) begin
            bad++; $display("FAIL pause_resume: got %0d want %0d", state, StRunning);
        end
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (cnt_en === 1'b1) begin
                gap = k;
                break;
            end
        end
        total++;
        if (gap != 2) begin
            bad++; $display("FAIL pause_phase: got %0d want 2", gap);
        end
        cmd_cycle(CmdClear);
        cycle();
    endtask

    task automatic test_lap_freeze();
        bit moved;
        moved = 0;
        set_cnt(12);
        cmd_cycle(CmdStart);
        cmd_cycle(CmdLap);
        total++;
        if (state !== StLap || lap_active !== 1'b1 || {disp_h, disp_t, disp_o} !== 12'h012) begin
            bad++; $display("FAIL lap_enter: got st=%0d lap=%b disp=%h want %0d/1/012",
                            state, lap_active, {disp_h, disp_t, disp_o}, StLap);
        end
        repeat (12) begin
            cycle();
            if ({disp_h, disp_t, disp_o} !== 12'h012) moved = 1;
        end
        total++;
        if (moved) begin
            bad++; $display("FAIL lap_frozen: got display change want 012 held");
        end
        total++;
        if (cnt_v != 15) begin
            bad++; $display("FAIL lap_counting: got %0d want 15", cnt_v);
        end
        cmd_cycle(CmdLap);
        total++;
        if ({disp_h, disp_t, disp_o} !== 12'h015 || lap_active !== 1'b0 || state !== StRunning)
        begin
            bad++; $display("FAIL lap_release: got disp=%h lap=%b st=%0d want 015/0/%0d",
                            {disp_h, disp_t, disp_o}, lap_active, state, StRunning);
        end
        cmd_cycle(CmdClear);
        cycle();
    endtask

    task automatic test_halt_999();
        bit saw_en;
        saw_en = 0;
        set_cnt(999);
        cmd_cycle(CmdStart);
        repeat (4) begin
            cycle();
            if (cnt_en !== 1'b0) saw_en = 1;
        end
        total++;
        if (saw_en || done !== 1'b1 || state !== StDone || running !== 1'b0) begin
            bad++; $display("FAIL halt_enter: got en=%b done=%b st=%0d want 0/1/%0d",
                            saw_en, done, state, StDone);
        end
        cmd_cycle(CmdStart);
        total++;
        if (state !== StDone) begin
            bad++; $display("FAIL halt_ignores_start: got %0d want %0d", state, StDone);
        end
        cmd_cycle(CmdClear);
        total++;
        if (cnt_clr !== 1'b1 || state !== StIdle || done !== 1'b0) begin
            bad++; $display("FAIL halt_clear: got clr=%b st=%0d done=%b want 1/%0d/0",
                            cnt_clr, state, done, StIdle);
        end
        cycle();
        total++;
        if (cnt_clr !== 1'b0) begin
            bad++; $display("FAIL halt_clear_width: got %b want 0", cnt_clr);
        end
    endtask

    task automatic test_clear_at_wrap();
        cmd_cycle(CmdStart);
        repeat (3) cycle();
        cmd_cycle(CmdClear);
        total++;
        if (cnt_en !== 1'b0 || cnt_clr !== 1'b1 || state !== StIdle) begin
            bad++; $display("FAIL clear_wrap: got en=%b clr=%b st=%0d want 0/1/%0d",
                            cnt_en, cnt_clr, state, StIdle);
        end
        cycle();
        total++;
        if (cnt_en !== 1'b0 || cnt_clr !== 1'b0) begin
            bad++; $display("FAIL clear_wrap_after: got en=%b clr=%b want 0/0", cnt_en, cnt_clr);
        end
    endtask

    task automatic test_reset_mid_run();
        cmd_cycle(CmdStart);
        cmd_cycle(CmdLap);
        repeat (2) cycle();
        rst = 1'b1;
        cmd = CmdLap; cmd_valid = 1'b1;
        cycle();
        rst = 1'b0;
        total++;
        if ({cnt_en, cnt_clr, running, lap_active, done} !== 5'b0 || state !== StIdle ||
            {disp_h, disp_t, disp_o} !== 12'h000) begin
            bad++; $display("FAIL reset_mid_run: got flags=%b st=%0d disp=%h want 00000/%0d/000",
                            {cnt_en, cnt_clr, running, lap_active, done}, state,
                            {disp_h, disp_t, disp_o}, StIdle);
        end
        cycle();
        total++;
        if (cnt_en !== 1'b0 || cnt_clr !== 1'b0 || state !== StIdle) begin
            bad++; $display("FAIL reset_no_pending: got en=%b clr=%b st=%0d want 0/0/%0d",
                            cnt_en, cnt_clr, state, StIdle);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cmd_valid = ($urandom_range(0, 4) == 0);
            cmd       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                if ($urandom_range(0, 1) == 1) set_cnt(995 + int'($urandom_range(0, 4)));
                else set_cnt(int'($urandom_range(0, 999)));
            end
            cycle();
            total++;
            if (state !== m_state) begin
                bad++; $display("FAIL rnd_state @%0d: got %0d want %0d", i, state, m_state);
            end
            total++;
            if (cnt_en !== m_en || cnt_clr !== m_clr) begin
                bad++; $display("FAIL rnd_strobes @%0d: got en=%b clr=%b want %b/%b",
                                i, cnt_en, cnt_clr, m_en, m_clr);
            end
            total++;
            if (disp_h !== 4'(m_disp / 100) || disp_t !== 4'((m_disp / 10) % 10) ||
                disp_o !== 4'(m_disp % 10)) begin
                bad++; $display("FAIL rnd_disp @%0d: got %h want %03d",
                                i, {disp_h, disp_t, disp_o}, m_disp);
            end
            total++;
            if (running !== (m_state == StRunning || m_state == StLap) ||
                lap_active !== (m_state == StLap) || done !== (m_state == StDone)) begin
                bad++; $display("FAIL rnd_flags @%0d: got %b%b%b for state %0d",
                                i, running, lap_active, done, m_state);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd = CmdStart;
        set_cnt(0);
        m_state = StIdle; m_phase = 0; m_en = 0; m_clr = 0; m_disp = 0;
        #2;
        test_reset();
        test_basic_run();
        test_pause_phase();
        test_lap_freeze();
        test_halt_999();
        test_clear_at_wrap();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000: clk cycles per count step; legal values are 2 or more.
REQ-002 Parameter WRAP, default 0: 0 = halt at 999, 1 = let counters roll 999->000.
REQ-003 clk  input  1  system clock, single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  one-cycle command strobe.
REQ-006 cmd  input  2  command code: 00 START, 01 STOP, 10 CLEAR, 11 LAP; ignored unless cmd_valid=1.
REQ-007 cnt_h, cnt_t, cnt_o  input  4 each  live BCD digits from the external counter chain.
REQ-008 cnt_en  output  1  one-cycle step enable to the ones counter.
REQ-009 cnt_clr  output  1  one-cycle synchronous clear to all three counters.
REQ-010 disp_h, disp_t, disp_o  output  4 each  digits to the hex display drivers.
REQ-011 running, lap_active, done  output  1 each  status flags.
REQ-012 state  output  3  current FSM state encoding.

Function
REQ-013 FSM states SHALL be IDLE, RUNNING, LAP, PAUSED and DONE; all outputs SHALL be registered.
REQ-014 A command sampled at edge N SHALL change the state at edge N; its effect on outputs SHALL be visible in cycle N+1.
REQ-015 IDLE: START goes to RUNNING; STOP, LAP and CLEAR are ignored.
REQ-016 RUNNING: STOP goes to PAUSED; CLEAR goes to IDLE; LAP goes to LAP and latches the current cnt digits into the disp registers.
REQ-017 LAP: counting continues and disp stays frozen; LAP goes to RUNNING and the display goes live; STOP goes to PAUSED and the display goes live; CLEAR goes to IDLE.
REQ-018 PAUSED: START goes to RUNNING; CLEAR goes to IDLE; STOP and LAP are ignored.
REQ-019 DONE: CLEAR goes to IDLE; all other commands are ignored.
REQ-020 Prescaler: counts 0..TICK_DIV-1 only in RUNNING and LAP, holds its value in PAUSED and DONE, and zeroes on CLEAR.
REQ-021 Prescaler wrap: on each edge where the prescaler wraps TICK_DIV-1->0, cnt_en SHALL be high for the following single cycle, so the first cnt_en comes TICK_DIV cycles after START is sampled.
REQ-022 Halt at 999: with WRAP=0, a prescaler wrap while cnt is 9,9,9 SHALL suppress cnt_en and enter DONE; with WRAP=1, cnt_en is issued normally.
REQ-023 CLEAR accepted in RUNNING, LAP, PAUSED or DONE SHALL give cnt_clr=1 for exactly one cycle.
REQ-024 Simultaneous command and prescaler wrap: the command wins.
  - STOP or CLEAR drops that step (cnt_en=0).
  - LAP keeps the step and latches the pre-step digits.
REQ-025 Live display: in every state except LAP, disp SHALL equal cnt delayed by one cycle.
REQ-026 Status flags:
  - running=1 in RUNNING or LAP.
  - lap_active=1 only in LAP.
  - done=1 only in DONE.

Reset
REQ-027 While rst=1 at an edge:
  - state = IDLE, prescaler = 0.
  - cnt_en, cnt_clr, running, lap_active, done = 0.
  - disp digits = 0.
REQ-028 rst SHALL override any cmd_valid sampled at the same edge.
REQ-029 A reset during RUNNING or LAP SHALL leave no pending cnt_en or cnt_clr in the cycle after reset.

Structure
REQ-030 A shared package stopwatch_pkg SHALL hold the state encoding (3-bit), the command codes and the BCD limit constant 9.
REQ-031 The prescaler SHALL be one sub-module, stopwatch_tick, with ports clk, rst, run, clear, tick and parameter TICK_DIV.
REQ-032 The FSM, the step gating and the display latch SHALL live in stopwatch_ctrl.

Verification (TICK_DIV=4)
REQ-033 Basic run: START, then 40 cycles -> exactly 10 cnt_en pulses, first pulse 4 cycles after START.
REQ-034 Pause keeps phase: START, STOP 6 cycles later, wait 20, START -> next cnt_en 2 cycles after the second START; state sequence is RUNNING, PAUSED, RUNNING.
REQ-035 Lap freeze: LAP while cnt=0,1,2 -> disp holds 0,1,2 while cnt advances to 0,1,5; second LAP -> disp=0,1,5 one cycle later and lap_active=0.
REQ-036 Halt at 999: WRAP=0, cnt=9,9,9 at a wrap -> cnt_en=0, done=1; START ignored; then CLEAR -> one cnt_clr pulse, state IDLE.
REQ-037 CLEAR at a wrap: CLEAR coincident with a prescaler wrap in RUNNING -> cnt_en=0 and cnt_clr=1 for one cycle.
REQ-038 Reset mid-run: rst asserted in LAP -> next cycle all outputs 0 and state IDLE.
